rt_rgu_scheduler: RTL and testbench
===================================

# rt_rgu_scheduler

Frame-scan controller for the 5-stage ray generation unit (RGU). It walks every pixel of a configured image in raster order and issues one Q14.18 (x, y) coordinate per cycle into the RGU. It buffers the returned rays in an output FIFO and delivers them downstream over a ready/valid stream with pixel tags. The RGU pipeline cannot stall, so the scheduler uses credits to guarantee that no ray is ever dropped.

## Interface
- FRAC_BITS, 18, fractional bits of RGU coordinate format (Q14.18)
- DIM_W, 16, width of pixel counters and image dimensions
- RGU_LATENCY, 5, cycles from rgu_start to rgu_valid
- FIFO_DEPTH, 8, output FIFO entries; must be ≥ RGU_LATENCY+2 for full rate
---
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_width, cfg_height  in  DIM_W  image size in pixels, sampled when frame_start is accepted
- frame_start  in  1  one-cycle request; ignored while busy=1
- busy  out  1  frame in progress (issuing or draining)
- frame_done  out  1  one-cycle pulse at frame end
- rgu_start  out  1  issue strobe to the RGU
- rgu_x, rgu_y  out  32  pixel coordinate, {pixel, FRAC_BITS'0}, e.g. x=3 -> 0x000C0000
- rgu_valid  in  1  RGU result valid
- rgu_origin, rgu_direction  in  3x32  RGU result vectors
- m_valid  out  1  output ray available
- m_ready  in  1  downstream accepts
- m_origin, m_direction  out  3x32  ray payload
- m_x, m_y  out  DIM_W  integer pixel tag of the ray on m_*
- m_last  out  1  set with the final ray of the frame
- err_overflow  out  1  sticky; rgu_valid arrived while FIFO full; cleared only by reset

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - frame_start with both dimensions ≠ 0 -> latch W and H, clear issue and output counters, go to ISSUE, busy=1.
  - frame_start with either dimension 0 -> frame_done pulses next cycle and the FSM stays in IDLE.
- ISSUE:
  - rgu_start=1 whenever credits > 0. On each issue, x increments.
  - At x=W-1: x wraps to 0 and y increments.
  - Issuing pixel (W-1, H-1) -> DRAIN.
- DRAIN: no issue. The handshake of the m_last beat -> IDLE, frame_done=1 that cycle+1, busy=0.
- Credits:
  - Reset value FIFO_DEPTH.
  - Issue decrements; each m_valid&&m_ready beat increments.
  - A simultaneous issue and pop leaves credits unchanged.
  - Credits never exceed FIFO_DEPTH and never go negative. This makes FIFO overflow impossible, so err_overflow flags only a broken RGU latency.
- Output tagging: rays return in order. The output side keeps its own (ox, oy) counter, advanced on each pop, which drives m_x/m_y.
  - m_last = (ox==W-1 && oy==H-1).
- rgu_valid with the FIFO full: the ray is dropped and err_overflow is set.
- Pixel counts are unsigned; W*H up to 2^(2·DIM_W) is supported with no overflow in counters.

## Timing
- Reset values:
  - busy, frame_done, rgu_start, m_valid, m_last, err_overflow = 0.
  - rgu_x, rgu_y, m_x, m_y, payloads = 0.
  - State = IDLE, credits = FIFO_DEPTH.
- frame_start sampled in cycle N -> first rgu_start in cycle N+1 with x=y=0.
- rgu_start, rgu_x and rgu_y are registered and change together.
- FIFO is registered (no fall-through). rgu_valid in cycle T -> m_valid no earlier than T+1.
- Issue-to-first-m_valid = RGU_LATENCY+1 cycles.
- A credit freed by a pop in cycle T is usable for issue in T+1.
- With m_ready=1 and FIFO_DEPTH ≥ RGU_LATENCY+2, throughput is 1 pixel/cycle.
- m_* payload is held stable while m_valid=1 and m_ready=0.
- Reset mid-frame aborts immediately:
  - FIFO emptied, state to IDLE, no frame_done.
  - The RGU shares this reset, so no stale rays return.

## Structure
- Shared package rt_pkg:
  - Q14.18 constant FRAC_BITS.
  - typedef vec3_t (3x32).
  - typedef ray_t {vec3_t origin, direction}.
  - Scheduler state enum.
- Sub-module rt_ray_fifo:
  - Synchronous FIFO of ray_t, DEPTH parameter.
  - push/pop, full/empty, registered outputs.
  - Same clk and async active-high reset.

## Test plan
Bench uses a behavioural RGU model with latency 5 that returns direction = {x, y, 0}.
- W=4, H=2, m_ready=1, frame_start at cycle 0:
  - rgu_start cycles 1–8, rgu_x = 0x0, 0x40000, 0x80000, 0xC0000, repeating for y=0x40000.
  - m_valid cycles 7–14; m_last only at (3,1).
  - frame_done at cycle 15.
- Same frame with m_ready=0 until cycle 30:
  - Exactly 8 issues occur, then rgu_start=0.
  - No err_overflow.
  - After m_ready rises, all 8 rays are delivered in order with correct m_x/m_y.
- m_ready toggled pseudo-randomly, W=5, H=3 -> 15 rays in raster order, payload stable under stall, credits never exceed 8.
- cfg_width=0 -> no rgu_start, frame_done one cycle after frame_start, busy stays 0.
- frame_start re-pulsed mid-frame is ignored. Reset asserted mid-ISSUE -> all outputs return to reset values asynchronously, and a following frame runs correctly from (0,0).

Source files
------------

// File: rtl/rt_pkg.sv
// Shared types for the ray-tracing front end: Q14.18 coordinate format, ray payload, scheduler states.
// No logic here; latency and backpressure live in the modules that use these types.
package rt_pkg;

  localparam int FRAC_BITS = 18;

  typedef logic [2:0][31:0] vec3_t;

  typedef struct packed {
    vec3_t origin;
    vec3_t direction;
  } ray_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic logic [31:0] pix_to_q(input logic [31:0] pix, input int frac);
    return pix << frac;
  endfunction

endpackage

// File: rtl/rt_ray_fifo.sv
// Ray FIFO with registered storage and no fall-through: a push is visible on the pop side next cycle.
// Push while full is discarded, pop while empty is ignored; the output word holds until popped.
module rt_ray_fifo
  import rt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  ray_t push_dat,
  input  logic pop,
  output ray_t pop_dat,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  ray_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rt_rgu_scheduler.sv
// Raster-scan issue controller for the RGU; first rgu_start one cycle after frame_start, rays out RGU_LATENCY+1 after issue.
// Credits cap in-flight plus buffered rays at FIFO_DEPTH, so m_ready backpressure stalls issue instead of dropping rays.
module rt_rgu_scheduler
  import rt_pkg::vec3_t, rt_pkg::ray_t, rt_pkg::pix_to_q;
  import rt_pkg::ST_IDLE, rt_pkg::ST_ISSUE, rt_pkg::ST_DRAIN;
#(
  parameter int FRAC_BITS   = rt_pkg::FRAC_BITS,
  parameter int DIM_W       = 16,
  parameter int RGU_LATENCY = 5,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic             frame_start,
  output logic             busy,
  output logic             frame_done,
  output logic             rgu_start,
  output logic [31:0]      rgu_x,
  output logic [31:0]      rgu_y,
  input  logic             rgu_valid,
  input  vec3_t            rgu_origin,
  input  vec3_t            rgu_direction,
  output logic             m_valid,
  input  logic             m_ready,
  output vec3_t            m_origin,
  output vec3_t            m_direction,
  output logic [DIM_W-1:0] m_x,
  output logic [DIM_W-1:0] m_y,
  output logic             m_last,
  output logic             err_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < RGU_LATENCY + 2) begin : g_depth_warn
    $warning("rt_rgu_scheduler: FIFO_DEPTH too shallow for one pixel per cycle");
  end

  logic [1:0]       state;
  logic [DIM_W-1:0] w_q, h_q;
  logic [DIM_W-1:0] nx, ny;
  logic [DIM_W-1:0] ox, oy;
  logic [CW-1:0]    credits;
  logic             start_q, done_q, err_q;
  logic [31:0]      x_q, y_q;

  logic             accept, dims_ok, start_ok, issue, last_issue;
  logic             pop, out_last, last_pop;
  logic [DIM_W-1:0] cur_x, cur_y, cur_w, cur_h;
  logic             fifo_full, fifo_empty;
  ray_t             fifo_in, fifo_out;

  // The accepting cycle already issues pixel (0,0) using the freshly sampled dimensions.
  always_comb begin
    accept     = frame_start && (state == ST_IDLE);
    dims_ok    = (cfg_width != '0) && (cfg_height != '0);
    start_ok   = accept && dims_ok;
    cur_x      = start_ok ? '0 : nx;
    cur_y      = start_ok ? '0 : ny;
    cur_w      = start_ok ? cfg_width : w_q;
    cur_h      = start_ok ? cfg_height : h_q;
    issue      = start_ok || ((state == ST_ISSUE) && (credits != '0));
    last_issue = (cur_x == cur_w - 1'b1) && (cur_y == cur_h - 1'b1);
    pop        = !fifo_empty && m_ready;
    out_last   = (ox == w_q - 1'b1) && (oy == h_q - 1'b1);
    last_pop   = pop && out_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      nx      <= '0;
      ny      <= '0;
      ox      <= '0;
      oy      <= '0;
      credits <= CW'(FIFO_DEPTH);
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      start_q <= issue;
      done_q  <= (accept && !dims_ok) || ((state == ST_DRAIN) && last_pop);

      if (issue) begin
        x_q <= pix_to_q(32'(cur_x), FRAC_BITS);
        y_q <= pix_to_q(32'(cur_y), FRAC_BITS);
        if (cur_x == cur_w - 1'b1) begin
          nx <= '0;
          ny <= cur_y + 1'b1;
        end else begin
          nx <= cur_x + 1'b1;
          ny <= cur_y;
        end
      end

      if (start_ok) begin
        w_q <= cfg_width;
        h_q <= cfg_height;
        ox  <= '0;
        oy  <= '0;
      end else if (pop) begin
        if (ox == w_q - 1'b1) begin
          ox <= '0;
          oy <= out_last ? '0 : oy + 1'b1;
        end else begin
          ox <= ox + 1'b1;
        end
      end

      case ({issue, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: ;
      endcase

      // Credits make this unreachable unless the RGU returns rays it was never asked for.
      if (rgu_valid && fifo_full) err_q <= 1'b1;

      case (state)
        ST_IDLE:  if (start_ok) state <= last_issue ? ST_DRAIN : ST_ISSUE;
        ST_ISSUE: if (issue && last_issue) state <= ST_DRAIN;
        ST_DRAIN: if (last_pop) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign fifo_in.origin    = rgu_origin;
  assign fifo_in.direction = rgu_direction;

  rt_ray_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (rgu_valid),
    .push_dat(fifo_in),
    .pop     (pop),
    .pop_dat (fifo_out),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign busy         = (state != ST_IDLE);
  assign frame_done   = done_q;
  assign rgu_start    = start_q;
  assign rgu_x        = x_q;
  assign rgu_y        = y_q;
  assign m_valid      = !fifo_empty;
  assign m_origin     = fifo_out.origin;
  assign m_direction  = fifo_out.direction;
  assign m_x          = ox;
  assign m_y          = oy;
  assign m_last       = !fifo_empty && out_last;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_rt_rgu_scheduler.sv
// Scoreboard bench for rt_rgu_scheduler: behavioural 5-cycle RGU, raster-order expectation queues, negedge monitor.
module tb_rt_rgu_scheduler;
  import rt_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cfg_width = '0, cfg_height = '0;
  logic        frame_start = 1'b0;
  logic        busy, frame_done, rgu_start;
  logic [31:0] rgu_x, rgu_y;
  logic        rgu_valid;
  vec3_t       rgu_origin, rgu_direction;
  logic        m_valid;
  logic        m_ready = 1'b0;
  vec3_t       m_origin, m_direction;
  logic [15:0] m_x, m_y;
  logic        m_last, err_overflow;

  always #5 clk = ~clk;

  rt_rgu_scheduler dut (
    .clk(clk), .reset(reset), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
    .rgu_start(rgu_start), .rgu_x(rgu_x), .rgu_y(rgu_y), .rgu_valid(rgu_valid),
    .rgu_origin(rgu_origin), .rgu_direction(rgu_direction), .m_valid(m_valid),
    .m_ready(m_ready), .m_origin(m_origin), .m_direction(m_direction),
    .m_x(m_x), .m_y(m_y), .m_last(m_last), .err_overflow(err_overflow)
  );

  // Behavioural RGU: fixed 5-cycle delay line sharing the scheduler reset.
  logic [4:0]       pv;
  logic [4:0][31:0] px, py;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0; px <= '0; py <= '0;
    end else begin
      pv <= {pv[3:0], rgu_start};
      px <= {px[3:0], rgu_x};
      py <= {py[3:0], rgu_y};
    end
  end
  assign rgu_valid     = pv[4];
  assign rgu_direction = {32'd0, py[4], px[4]};
  assign rgu_origin    = {32'h1234_5678, py[4] + 32'd2, px[4] ^ 32'hA5A5_0000};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk_eq(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] q18(input int v);
    return 32'(v) * 32'd262144;
  endfunction

  typedef struct { int x; int y; bit last; } pix_t;
  pix_t exp_q[$];
  pix_t iss_q[$];
  pix_t mp, ip;

  int n_start, first_start, last_start, first_mv, last_pop_cyc, n_pop;
  int done_count, done_cyc, iss_tot, pop_tot;
  bit busy_seen, credit_bad, held_vld;
  vec3_t held_o, held_d;
  logic [15:0] held_x, held_y;

  task automatic clear_stats();
    n_start = 0; first_start = -1; last_start = -1; first_mv = -1; last_pop_cyc = -1;
    n_pop = 0; done_count = 0; done_cyc = -1; iss_tot = 0; pop_tot = 0;
    busy_seen = 0; credit_bad = 0; held_vld = 0;
  endtask

  task automatic fill_expected(input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        iss_q.push_back('{x, y, 1'b0});
        exp_q.push_back('{x, y, (x == w - 1) && (y == h - 1)});
      end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rgu_start) begin
        n_start++; iss_tot++;
        if (first_start < 0) first_start = cyc;
        last_start = cyc;
        if (iss_q.size() == 0) chk_eq("issue_unexpected", 96'(rgu_x), 96'hFFFF_FFFF);
        else begin
          ip = iss_q.pop_front();
          chk_eq("rgu_x", 96'(rgu_x), 96'(q18(ip.x)));
          chk_eq("rgu_y", 96'(rgu_y), 96'(q18(ip.y)));
        end
      end
      if (m_valid && first_mv < 0) first_mv = cyc;
      if (held_vld) begin
        chk_eq("stall_valid", 96'(m_valid), 96'd1);
        chk_eq("stall_origin", m_origin, held_o);
        chk_eq("stall_direction", m_direction, held_d);
        chk_eq("stall_tag", {64'd0, m_x, m_y}, {64'd0, held_x, held_y});
      end
      held_vld = m_valid && !m_ready;
      held_o = m_origin; held_d = m_direction; held_x = m_x; held_y = m_y;
      if (m_valid && m_ready) begin
        n_pop++; pop_tot++; last_pop_cyc = cyc;
        if (exp_q.size() == 0) chk_eq("ray_unexpected", 96'(m_x), 96'hFFFF);
        else begin
          mp = exp_q.pop_front();
          chk_eq("m_x", 96'(m_x), 96'(mp.x));
          chk_eq("m_y", 96'(m_y), 96'(mp.y));
          chk_eq("m_last", 96'(m_last), 96'(mp.last));
          chk_eq("m_direction", m_direction, {32'd0, q18(mp.y), q18(mp.x)});
          chk_eq("m_origin", m_origin,
                 {32'h1234_5678, q18(mp.y) + 32'd2, q18(mp.x) ^ 32'hA5A5_0000});
        end
      end
      if (iss_tot - pop_tot > 8) credit_bad = 1;
      if (frame_done) begin done_count++; done_cyc = cyc; end
      if (busy) busy_seen = 1;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk_eq({tag, "_busy"}, 96'(busy), 96'd0);
    chk_eq({tag, "_frame_done"}, 96'(frame_done), 96'd0);
    chk_eq({tag, "_rgu_start"}, 96'(rgu_start), 96'd0);
    chk_eq({tag, "_m_valid"}, 96'(m_valid), 96'd0);
    chk_eq({tag, "_m_last"}, 96'(m_last), 96'd0);
    chk_eq({tag, "_err_overflow"}, 96'(err_overflow), 96'd0);
    chk_eq({tag, "_rgu_xy"}, {32'd0, rgu_x, rgu_y}, 96'd0);
    chk_eq({tag, "_m_xy"}, {64'd0, m_x, m_y}, 96'd0);
    chk_eq({tag, "_m_origin"}, m_origin, 96'd0);
    chk_eq({tag, "_m_direction"}, m_direction, 96'd0);
  endtask

  // mode 0: m_ready=1; mode 1: m_ready=0 until c0+30; mode 2: random m_ready.
  task automatic run_frame(input int w, input int h, input int mode, input bit repulse,
                           output int c0);
    clear_stats();
    fill_expected(w, h);
    @(posedge clk); #1;
    cfg_width = 16'(w); cfg_height = 16'(h); frame_start = 1'b1;
    m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    c0 = cyc;
    for (int k = 0; k < 600 && done_count == 0; k++) begin
      @(posedge clk); #1;
      frame_start = repulse && (cyc == c0 + 3);
      if (frame_start) begin cfg_width = 16'd7; cfg_height = 16'd1; end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc >= c0 + 30);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 1 && cyc == c0 + 30) begin
        chk_eq("stalled_issue_count", 96'(n_start), 96'd8);
        chk_eq("stalled_rgu_start", 96'(rgu_start), 96'd0);
      end
    end
    m_ready = 1'b1; frame_start = 1'b0;
    chk_eq("frame_done_timeout", 96'(done_count > 0), 96'd1);
    repeat (3) @(posedge clk);
    #1;
    chk_eq("frame_done_count", 96'(done_count), 96'd1);
    chk_eq("issue_queue_left", 96'(iss_q.size()), 96'd0);
    chk_eq("ray_queue_left", 96'(exp_q.size()), 96'd0);
    chk_eq("err_overflow", 96'(err_overflow), 96'd0);
    chk_eq("busy_after_frame", 96'(busy), 96'd0);
    chk_eq("credit_bound", 96'(credit_bad), 96'd0);
  endtask

  int c0;

  initial begin
    clear_stats();
    #1 reset = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Nominal 4x2 frame at full rate
    run_frame(4, 2, 0, 0, c0);
    chk_eq("t1_first_start", 96'(first_start), 96'(c0 + 1));
    chk_eq("t1_last_start", 96'(last_start), 96'(c0 + 8));
    chk_eq("t1_n_start", 96'(n_start), 96'd8);
    chk_eq("t1_first_m_valid", 96'(first_mv), 96'(c0 + 7));
    chk_eq("t1_last_pop", 96'(last_pop_cyc), 96'(c0 + 14));
    chk_eq("t1_frame_done_cyc", 96'(done_cyc), 96'(c0 + 15));

    // Same frame, downstream blocked until cycle 30
    run_frame(4, 2, 1, 0, c0);
    chk_eq("t2_n_start", 96'(n_start), 96'd8);
    chk_eq("t2_n_pop", 96'(n_pop), 96'd8);

    // 5x3 with random backpressure
    run_frame(5, 3, 2, 0, c0);
    chk_eq("t3_n_pop", 96'(n_pop), 96'd15);
    chk_eq("t3_n_start", 96'(n_start), 96'd15);

    // Zero-sized frames complete immediately without issuing
    run_frame(0, 3, 0, 0, c0);
    chk_eq("t4_n_start", 96'(n_start), 96'd0);
    chk_eq("t4_done_cyc", 96'(done_cyc), 96'(c0 + 1));
    chk_eq("t4_busy_seen", 96'(busy_seen), 96'd0);
    run_frame(2, 0, 0, 0, c0);
    chk_eq("t4b_done_cyc", 96'(done_cyc), 96'(c0 + 1));
    chk_eq("t4b_busy_seen", 96'(busy_seen), 96'd0);

    // frame_start re-pulsed mid-frame is ignored
    run_frame(3, 2, 0, 1, c0);
    chk_eq("t5_n_pop", 96'(n_pop), 96'd6);

    // Reset during ISSUE aborts the frame
    clear_stats();
    fill_expected(6, 4);
    @(posedge clk); #1;
    cfg_width = 16'd6; cfg_height = 16'd4; frame_start = 1'b1; m_ready = 1'b0;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk_eq("t6_busy_before_abort", 96'(busy), 96'd1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1 check_reset_outputs("abort");
    iss_q.delete(); exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1 chk_eq("t6_no_frame_done", 96'(done_count), 96'd0);
    run_frame(2, 2, 0, 0, c0);
    chk_eq("t6_first_start", 96'(first_start), 96'(c0 + 1));
    chk_eq("t6_n_pop", 96'(n_pop), 96'd4);
    chk_eq("t6_frame_done_cyc", 96'(done_cyc), 96'(c0 + 11));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
